// File: rtl/dds_pkg.sv
// Shared types, constants and elaboration-time ROM helpers for the dds_gen DDS.
package dds_pkg;

  localparam real PI = 3.14159265358979323846;

  typedef logic [1:0] quadrant_t;

  // Largest symmetric amplitude, 2^(dw-1)-1, so the negative full-scale code is never produced.
  function automatic int amp(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Sine entry for table index idx. The full table is folded from the first quadrant so it is
  // bit-identical to the quarter-wave build; rounding is half away from zero.
  function automatic int gen_lut(input int pw, input int dw, input bit quarter, input int idx);
    int  n4;
    int  r;
    bit  neg;
    real x;
    int  v;
    n4 = 1 << (pw - 2);
    if (quarter) begin
      r   = idx;
      neg = 1'b0;
    end else begin
      r   = (((idx / n4) % 2) == 1) ? n4 - (idx % n4) : idx % n4;
      neg = (idx / n4) >= 2;
    end
    x = real'(amp(dw)) * $sin(2.0 * PI * real'(r) / real'(4 * n4));
    v = int'($floor(x + 0.5));
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/dds_lut.sv
// Registered cos/sin lookup. Define DDS_QUARTER_WAVE_EN for a quarter-wave sine ROM with
// quadrant mirroring; otherwise full cos and sin tables are used.
module dds_lut
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 14,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          en_i,
  input  logic [PHASE_WIDTH-1:0]        phase_i,
  output logic signed [DATA_WIDTH-1:0]  cos_o,
  output logic signed [DATA_WIDTH-1:0]  sin_o
);

  localparam int N  = 1 << PHASE_WIDTH;
  localparam int N4 = N / 4;

  logic signed [DATA_WIDTH-1:0] cos_d, cos_q;
  logic signed [DATA_WIDTH-1:0] sin_d, sin_q;

`ifdef DDS_QUARTER_WAVE_EN
  logic signed [DATA_WIDTH-1:0] rom [N4+1];
  quadrant_t                    quad_sin, quad_cos;
  logic [PHASE_WIDTH-2:0]       offs, addr_sin, addr_cos;

  for (genvar i = 0; i <= N4; i++) begin : g_rom
    localparam int V = gen_lut(PHASE_WIDTH, DATA_WIDTH, 1'b1, i);
    assign rom[i] = DATA_WIDTH'(V);
  end

  // cos(p) = sin(p + N/4): the cosine path is the sine path one quadrant ahead.
  always_comb begin
    quad_sin = phase_i[PHASE_WIDTH-1 -: 2];
    quad_cos = quad_sin + 2'd1;
    offs     = {1'b0, phase_i[PHASE_WIDTH-3:0]};
    addr_sin = quad_sin[0] ? (PHASE_WIDTH-1)'(N4) - offs : offs;
    addr_cos = quad_cos[0] ? (PHASE_WIDTH-1)'(N4) - offs : offs;
    sin_d    = quad_sin[1] ? -rom[addr_sin] : rom[addr_sin];
    cos_d    = quad_cos[1] ? -rom[addr_cos] : rom[addr_cos];
  end
`else
  logic signed [DATA_WIDTH-1:0] rom_cos [N];
  logic signed [DATA_WIDTH-1:0] rom_sin [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam int VS = gen_lut(PHASE_WIDTH, DATA_WIDTH, 1'b0, i);
    localparam int VC = gen_lut(PHASE_WIDTH, DATA_WIDTH, 1'b0, (i + N4) % N);
    assign rom_sin[i] = DATA_WIDTH'(VS);
    assign rom_cos[i] = DATA_WIDTH'(VC);
  end

  always_comb begin
    cos_d = rom_cos[phase_i];
    sin_d = rom_sin[phase_i];
  end
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (en_i) begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_o = cos_q;
  assign sin_o = sin_q;

endmodule

// File: rtl/dds_gen.sv
// DDS top: phase accumulator, offset adder and valid pipeline around dds_lut.
// Build option DDS_QUARTER_WAVE_EN selects the quarter-wave ROM inside dds_lut.
module dds_gen
  import dds_pkg::*;
#(
  parameter int IQ_NUM      = 2,
  parameter int PHASE_WIDTH = 14,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               en_i,
  input  logic [PHASE_WIDTH-1:0]             phase_inc_i,
  input  logic [PHASE_WIDTH-1:0]             phase_offset_i,
  output logic                               tvalid_o,
  output logic [IQ_NUM-1:0][DATA_WIDTH-1:0]  tdata_o
);

  logic [PHASE_WIDTH-1:0]       acc_d, acc_q;
  logic [PHASE_WIDTH-1:0]       ph1_d, ph1_q;
  logic                         v1_d, v1_q;
  logic                         tvalid_d, tvalid_q;
  logic signed [DATA_WIDTH-1:0] cos_w, sin_w;

  always_comb begin
    acc_d    = acc_q;
    ph1_d    = ph1_q;
    v1_d     = en_i;
    tvalid_d = v1_q;
    if (en_i) begin
      acc_d = acc_q + phase_inc_i;
      ph1_d = acc_q + phase_offset_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q    <= '0;
      ph1_q    <= '0;
      v1_q     <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      ph1_q    <= ph1_d;
      v1_q     <= v1_d;
      tvalid_q <= tvalid_d;
    end
  end

  dds_lut #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (v1_q),
    .phase_i(ph1_q),
    .cos_o  (cos_w),
    .sin_o  (sin_w)
  );

  assign tvalid_o   = tvalid_q;
  assign tdata_o[0] = cos_w;

  if (IQ_NUM > 1) begin : g_q
    assign tdata_o[1] = sin_w;
  end

endmodule

// File: tb/tb_dds_gen.sv
// Directed self-checking bench for dds_gen at default parameters (P=14, D=16, A=32767).
module tb_dds_gen;

  localparam real PI = 3.14159265358979323846;

  logic             clk;
  logic             rstn;
  logic             en;
  logic [13:0]      inc;
  logic [13:0]      off;
  logic             tvalid;
  logic [1:0][15:0] tdata;

  int checks = 0;
  int errors = 0;

  int s3_i [4] = '{32767, 0, -32767, 0};
  int s3_q [4] = '{0, 32767, 0, -32767};

  dds_gen #(
    .IQ_NUM     (2),
    .PHASE_WIDTH(14),
    .DATA_WIDTH (16)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .phase_inc_i   (inc),
    .phase_offset_i(off),
    .tvalid_o      (tvalid),
    .tdata_o       (tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  function automatic int model_cos(input int p);
    return rnd(32767.0 * $cos(2.0 * PI * real'(p) / 16384.0));
  endfunction

  function automatic int model_sin(input int p);
    return rnd(32767.0 * $sin(2.0 * PI * real'(p) / 16384.0));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int i_exp, input int q_exp);
    check({tag, "_valid"}, int'(tvalid), v);
    check({tag, "_I"}, int'($signed(tdata[0])), i_exp);
    check({tag, "_Q"}, int'($signed(tdata[1])), q_exp);
  endtask

  task automatic restart();
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    inc  = 14'd4096;
    off  = '0;

    // reset held, then idle with en=0 while a nonzero increment is presented
    repeat (3) @(negedge clk);
    chk_out("reset_hold", 0, 0, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("idle_en0", 0, 0, 0);

    // inc=0, off=0: first sample uses phase 0, proving acc did not move while idle
    inc = '0;
    en  = 1'b1;
    @(negedge clk);
    check("latency_1clk_valid", int'(tvalid), 0);
    @(negedge clk);
    chk_out("s2_first", 1, 32767, 0);
    repeat (3) begin
      @(negedge clk);
      chk_out("s2_const", 1, 32767, 0);
    end

    // quarter-turn steps
    restart();
    inc = 14'd4096;
    off = '0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk_out("s3_quarter", 1, s3_i[k % 4], s3_q[k % 4]);
      @(negedge clk);
    end

    // static offsets, with an offset change taking effect on the next launched sample
    restart();
    inc = '0;
    off = 14'd4096;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("s4_off4096", 1, 0, 32767);
    off = 14'd8192;
    @(negedge clk);
    chk_out("s4_off_pipe", 1, 0, 32767);
    @(negedge clk);
    chk_out("s4_off8192", 1, -32767, 0);
    @(negedge clk);
    chk_out("s4_off8192_hold", 1, -32767, 0);

    // gap in en: three invalid cycles, data held, phase continues afterwards
    restart();
    inc = 14'd4096;
    off = '0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("s6_pre0", 1, 32767, 0);
    en = 1'b0;
    @(negedge clk);
    chk_out("s6_pre1", 1, 0, 32767);
    @(negedge clk);
    chk_out("s6_gap0", 0, 0, 32767);
    @(negedge clk);
    chk_out("s6_gap1", 0, 0, 32767);
    en = 1'b1;
    @(negedge clk);
    chk_out("s6_gap2", 0, 0, 32767);
    @(negedge clk);
    chk_out("s6_resume0", 1, -32767, 0);
    @(negedge clk);
    chk_out("s6_resume1", 1, 0, -32767);

    // asynchronous reset between clock edges, then restart from phase 0
    #2 rstn = 1'b0;
    #1 chk_out("s6_async_rst", 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("s6_rst_lat_valid", int'(tvalid), 0);
    @(negedge clk);
    chk_out("s6_restart0", 1, 32767, 0);
    @(negedge clk);
    chk_out("s6_restart1", 1, 0, 32767);

    // 20 MHz at 100 MHz against the real-math model, including many accumulator wraps
    restart();
    inc = 14'd3276;
    off = '0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3000; k++) begin
      chk_out("s5_tone", 1, model_cos((k * 3276) % 16384), model_sin((k * 3276) % 16384));
      @(negedge clk);
    end

    restart();
    inc = 14'd3276;
    off = 14'd1234;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      chk_out("s5_tone_off", 1, model_cos((k * 3276 + 1234) % 16384),
              model_sin((k * 3276 + 1234) % 16384));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
